// File: rtl/mem_cycle_ctrl_pkg.sv
// Shared definitions for the CPU memory cycle controller:
// bank-register addresses, field positions, timeout and FSM states.
package mem_cycle_ctrl_pkg;

  localparam logic [11:0] EB_ADDR = 12'h003;
  localparam logic [11:0] FB_ADDR = 12'h004;
  localparam logic [11:0] BB_ADDR = 12'h006;

  localparam int EB_LSB    = 8;
  localparam int FB_LSB    = 10;
  localparam int BB_EB_LSB = 0;

  localparam int TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REG,
    ST_MEM,
    ST_DONE
  } state_e;

  function automatic logic isBankReg(input logic [11:0] addr);
    return (addr == EB_ADDR) || (addr == FB_ADDR) || (addr == BB_ADDR);
  endfunction

endpackage

// File: rtl/mem_cycle_ctrl_banks.sv
// Bank register storage (eBank, fBank, superBank) with the register read
// mux and the deferred superbank update applied when the FSM returns to idle.
module mem_bank_regs
  import mem_cycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inIdle_i,
  input  logic        enterIdle_i,
  input  logic        regWe_i,
  input  logic [11:0] regAddr_i,
  input  logic [15:0] regWdata_i,
  input  logic        sbWe_i,
  input  logic        sbData_i,
  output logic [2:0]  eBank_o,
  output logic [4:0]  fBank_o,
  output logic        superBank_o,
  output logic [15:0] regRdata_o
);

  logic [2:0] eBank_q, eBank_d;
  logic [4:0] fBank_q, fBank_d;
  logic       sb_q, sb_d;
  logic       pend_q, pend_d;
  logic       pendVal_q, pendVal_d;
  logic       unusedWdata;

  assign unusedWdata = ^{regWdata_i[15], regWdata_i[7:3]};

  // BB is only a second view of the same eBank/fBank storage.
  always_comb begin
    regRdata_o = '0;
    case (regAddr_i)
      EB_ADDR: regRdata_o[EB_LSB +: 3] = eBank_q;
      FB_ADDR: regRdata_o[FB_LSB +: 5] = fBank_q;
      BB_ADDR: begin
        regRdata_o[FB_LSB +: 5]    = fBank_q;
        regRdata_o[BB_EB_LSB +: 3] = eBank_q;
      end
      default: regRdata_o = '0;
    endcase
  end

  always_comb begin
    eBank_d   = eBank_q;
    fBank_d   = fBank_q;
    sb_d      = sb_q;
    pend_d    = pend_q;
    pendVal_d = pendVal_q;
    if (regWe_i) begin
      case (regAddr_i)
        EB_ADDR: eBank_d = regWdata_i[EB_LSB +: 3];
        FB_ADDR: fBank_d = regWdata_i[FB_LSB +: 5];
        BB_ADDR: begin
          fBank_d = regWdata_i[FB_LSB +: 5];
          eBank_d = regWdata_i[BB_EB_LSB +: 3];
        end
        default: ;
      endcase
    end
    // A strobe on the very edge back into idle is the latest one, so it wins.
    if (inIdle_i) begin
      if (sbWe_i) sb_d = sbData_i;
    end else if (enterIdle_i) begin
      if (sbWe_i)      sb_d = sbData_i;
      else if (pend_q) sb_d = pendVal_q;
      pend_d = 1'b0;
    end else if (sbWe_i) begin
      pend_d    = 1'b1;
      pendVal_d = sbData_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      eBank_q   <= '0;
      fBank_q   <= '0;
      sb_q      <= 1'b0;
      pend_q    <= 1'b0;
      pendVal_q <= 1'b0;
    end else begin
      eBank_q   <= eBank_d;
      fBank_q   <= fBank_d;
      sb_q      <= sb_d;
      pend_q    <= pend_d;
      pendVal_q <= pendVal_d;
    end
  end

  assign eBank_o     = eBank_q;
  assign fBank_o     = fBank_q;
  assign superBank_o = sb_q;

endmodule

// File: rtl/mem_cycle_ctrl.sv
// CPU memory cycle controller: captures a CPU request, serves bank registers
// internally, blocks fixed-memory writes and runs a timed memory access.
module mem_cycle_ctrl
  import mem_cycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpuReq_i,
  input  logic        cpuWe_i,
  input  logic [11:0] cpuAddr_i,
  input  logic [15:0] cpuWdata_i,
  output logic        cpuAck_o,
  output logic [15:0] cpuRdata_o,
  output logic        cpuFault_o,
  input  logic        sbWe_i,
  input  logic        sbData_i,
  output logic [11:0] memAddr_o,
  output logic [2:0]  eBank_o,
  output logic [4:0]  fBank_o,
  output logic        superBank_o,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [15:0] memWdata_o,
  input  logic [15:0] memRdata_i,
  input  logic        memAck_i
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [15:0] regRdata;
  logic        inIdle, enterIdle, regWe;

  assign inIdle    = (state_q == ST_IDLE);
  assign enterIdle = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  assign regWe     = (state_q == ST_REG) && we_q;

  mem_bank_regs u_banks (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .inIdle_i    (inIdle),
    .enterIdle_i (enterIdle),
    .regWe_i     (regWe),
    .regAddr_i   (addr_q),
    .regWdata_i  (wdata_q),
    .sbWe_i      (sbWe_i),
    .sbData_i    (sbData_i),
    .eBank_o     (eBank_o),
    .fBank_o     (fBank_o),
    .superBank_o (superBank_o),
    .regRdata_o  (regRdata)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    cpuAck_o   = 1'b0;
    cpuRdata_o = '0;
    cpuFault_o = 1'b0;
    memReq_o   = 1'b0;
    memWe_o    = 1'b0;
    memWdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        rdata_d = '0;
        fault_d = 1'b0;
        if (cpuReq_i) begin
          we_d    = cpuWe_i;
          addr_d  = cpuAddr_i;
          wdata_d = cpuWdata_i;
          if (isBankReg(cpuAddr_i)) begin
            state_d = ST_REG;
          end else if (cpuWe_i && (cpuAddr_i[11:10] != 2'b00)) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_REG: begin
        cpuAck_o   = 1'b1;
        cpuRdata_o = we_q ? 16'h0000 : regRdata;
        state_d    = ST_IDLE;
      end
      ST_MEM: begin
        memReq_o   = 1'b1;
        memWe_o    = we_q;
        memWdata_o = wdata_q;
        cnt_d      = cnt_q + 4'd1;
        // An ack on the final allowed cycle still beats the timeout.
        if (memAck_i) begin
          rdata_d = we_q ? 16'h0000 : memRdata_i;
          state_d = ST_DONE;
        end else if (cnt_q == 4'(TIMEOUT - 1)) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cpuAck_o   = 1'b1;
        cpuRdata_o = rdata_q;
        cpuFault_o = fault_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign memAddr_o = addr_q;

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Self-checking bench for mem_cycle_ctrl: directed scenarios plus a scoreboard
// of expected {cpuFault, cpuRdata} popped on every cpuAck.
module tb_mem_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpuReq = 1'b0, cpuWe = 1'b0;
  logic [11:0] cpuAddr = '0;
  logic [15:0] cpuWdata = '0;
  logic        cpuAck, cpuFault;
  logic [15:0] cpuRdata;
  logic        sbWe = 1'b0, sbData = 1'b0;
  logic [11:0] memAddr;
  logic [2:0]  eBank;
  logic [4:0]  fBank;
  logic        superBank, memReq, memWe;
  logic [15:0] memWdata;
  logic [15:0] memRdata = '0;
  logic        memAck = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [16:0] expQ[$];
  logic [16:0] expItem;
  int          memDelay = -1;
  int          memCnt = 0;
  logic [15:0] memData = '0;

  mem_cycle_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cpuReq_i    (cpuReq),
    .cpuWe_i     (cpuWe),
    .cpuAddr_i   (cpuAddr),
    .cpuWdata_i  (cpuWdata),
    .cpuAck_o    (cpuAck),
    .cpuRdata_o  (cpuRdata),
    .cpuFault_o  (cpuFault),
    .sbWe_i      (sbWe),
    .sbData_i    (sbData),
    .memAddr_o   (memAddr),
    .eBank_o     (eBank),
    .fBank_o     (fBank),
    .superBank_o (superBank),
    .memReq_o    (memReq),
    .memWe_o     (memWe),
    .memWdata_o  (memWdata),
    .memRdata_i  (memRdata),
    .memAck_i    (memAck)
  );

  always #5 clk = ~clk;

  // Memory model: acks in the memDelay-th cycle of memReq (never if < 1).
  always @(negedge clk) begin
    memRdata = memData;
    if (memReq === 1'b1) begin
      memCnt = memCnt + 1;
      memAck = (memDelay > 0) && (memCnt == memDelay);
    end else begin
      memCnt = 0;
      memAck = 1'b0;
    end
  end

  // Scoreboard: every completion must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && cpuAck === 1'b1) begin
      vectors = vectors + 1;
      if (expQ.size() == 0) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL unexpected_ack: got rdata=%h fault=%b, no completion expected", cpuRdata, cpuFault);
      end else begin
        expItem = expQ.pop_front();
        if ({cpuFault, cpuRdata} !== expItem) begin
          miscompares = miscompares + 1;
          $display("[TB] FAIL completion: got fault=%b rdata=%h, expected fault=%b rdata=%h",
                   cpuFault, cpuRdata, expItem[16], expItem[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic startReq(input logic we, input logic [11:0] addr, input logic [15:0] wdata);
    cpuWe    = we;
    cpuAddr  = addr;
    cpuWdata = wdata;
    cpuReq   = 1'b1;
    @(negedge clk);
    cpuReq   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors = vectors + 1;
    if ({cpuAck, cpuFault, cpuRdata, memReq, memWe, memWdata, memAddr, eBank, fBank, superBank} !== 57'd0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_outputs: got nonzero outputs, ack=%b req=%b addr=%h eb=%b fb=%b sb=%b, expected all 0",
               cpuAck, memReq, memAddr, eBank, fBank, superBank);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors = vectors + 1;
    if ({cpuAck, memReq} !== 2'b00) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL idle_after_reset: got ack=%b req=%b, expected 0 0", cpuAck, memReq);
    end
  endtask

  task automatic test_fb_and_read();
    expQ.push_back({1'b0, 16'h0000});
    startReq(1'b1, 12'h004, 16'h5400);
    vectors = vectors + 1;
    if (cpuAck !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reg_latency: got cpuAck=%b, expected 1", cpuAck);
    end
    @(negedge clk);
    vectors = vectors + 1;
    if (fBank !== 5'b10101) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL fb_write: got fBank=%b, expected 10101", fBank);
    end
    memDelay = 2;
    memData  = 16'h1234;
    expQ.push_back({1'b0, 16'h1234});
    startReq(1'b0, 12'h7E0, 16'h0000);
    vectors = vectors + 1;
    if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 12'h7E0}) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL mem_read_start: got req=%b we=%b addr=%h, expected 1 0 7e0", memReq, memWe, memAddr);
    end
    vectors = vectors + 1;
    if ({fBank, memAddr[9:0]} !== 15'h57E0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL mapped_addr: got %h, expected 57e0", {fBank, memAddr[9:0]});
    end
    @(negedge clk);
    vectors = vectors + 1;
    if ({memReq, cpuAck} !== 2'b10) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL mem_wait: got req=%b ack=%b, expected 1 0", memReq, cpuAck);
    end
    @(negedge clk);
    vectors = vectors + 1;
    if ({memReq, cpuAck} !== 2'b01) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL mem_read_ack: got req=%b ack=%b, expected 0 1", memReq, cpuAck);
    end
    @(negedge clk);
  endtask

  task automatic test_bb_view();
    expQ.push_back({1'b0, 16'h0000});
    startReq(1'b1, 12'h006, 16'h7005);
    @(negedge clk);
    vectors = vectors + 1;
    if ({eBank, fBank} !== {3'b101, 5'b11100}) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL bb_write: got eBank=%b fBank=%b, expected 101 11100", eBank, fBank);
    end
    expQ.push_back({1'b0, 16'h0500});
    startReq(1'b0, 12'h003, 16'h0000);
    @(negedge clk);
    expQ.push_back({1'b0, 16'h7000});
    startReq(1'b0, 12'h004, 16'h0000);
    @(negedge clk);
    expQ.push_back({1'b0, 16'h7005});
    startReq(1'b0, 12'h006, 16'h0000);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    memDelay = -1;
    startReq(1'b0, 12'h333, 16'h0000);
    @(negedge clk);
    vectors = vectors + 1;
    if (memReq !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL mid_mem_req: got memReq=%b, expected 1", memReq);
    end
    #2 reset = 1'b1;
    #1;
    vectors = vectors + 1;
    if ({cpuAck, cpuFault, cpuRdata, memReq, memWe, memWdata, memAddr, eBank, fBank, superBank} !== 57'd0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL async_reset: got req=%b ack=%b addr=%h eb=%b fb=%b, expected all 0",
               memReq, cpuAck, memAddr, eBank, fBank);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors = vectors + 1;
    if ({memReq, cpuAck} !== 2'b00) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL post_reset_idle: got req=%b ack=%b, expected 0 0", memReq, cpuAck);
    end
  endtask

  task automatic test_blocked_write();
    expQ.push_back({1'b1, 16'h0000});
    startReq(1'b1, 12'h871, 16'hBEEF);
    vectors = vectors + 1;
    if ({memReq, cpuAck, cpuFault} !== 3'b011) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL blocked_write: got req=%b ack=%b fault=%b, expected 0 1 1", memReq, cpuAck, cpuFault);
    end
    @(negedge clk);
    vectors = vectors + 1;
    if ({memReq, cpuAck} !== 2'b00) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL blocked_after: got req=%b ack=%b, expected 0 0", memReq, cpuAck);
    end
  endtask

  task automatic test_mem_write();
    memDelay = 1;
    memData  = 16'hFFFF;
    expQ.push_back({1'b0, 16'h0000});
    startReq(1'b1, 12'h123, 16'hA5A5);
    vectors = vectors + 1;
    if ({memReq, memWe, memWdata, memAddr} !== {1'b1, 1'b1, 16'hA5A5, 12'h123}) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL mem_write_drive: got req=%b we=%b wdata=%h addr=%h, expected 1 1 a5a5 123",
               memReq, memWe, memWdata, memAddr);
    end
    @(negedge clk);
    vectors = vectors + 1;
    if (cpuAck !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL min_round_trip: got cpuAck=%b, expected 1", cpuAck);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    for (int v = 0; v < 2; v++) begin
      memDelay = (v == 0) ? -1 : 15;
      memData  = 16'hCAFE;
      expQ.push_back((v == 0) ? {1'b1, 16'h0000} : {1'b0, 16'hCAFE});
      startReq(1'b0, 12'h333, 16'h0000);
      n = 0;
      while (memReq === 1'b1 && n < 20) begin
        n = n + 1;
        @(negedge clk);
      end
      vectors = vectors + 1;
      if (n != 15 || cpuAck !== 1'b1) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL timeout_len_%0d: got %0d req cycles ack=%b, expected 15 cycles ack=1", v, n, cpuAck);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_superbank();
    memDelay = 3;
    memData  = 16'h0042;
    expQ.push_back({1'b0, 16'h0042});
    startReq(1'b0, 12'h200, 16'h0000);
    sbData = 1'b1;
    sbWe   = 1'b1;
    @(negedge clk);
    sbWe   = 1'b0;
    vectors = vectors + 1;
    if (superBank !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL sb_deferred_mem: got superBank=%b, expected 0", superBank);
    end
    @(negedge clk);
    @(negedge clk);
    vectors = vectors + 1;
    if ({cpuAck, superBank} !== 2'b10) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL sb_deferred_done: got ack=%b superBank=%b, expected 1 0", cpuAck, superBank);
    end
    @(negedge clk);
    vectors = vectors + 1;
    if (superBank !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL sb_applied_idle: got superBank=%b, expected 1", superBank);
    end
    sbData = 1'b0;
    sbWe   = 1'b1;
    @(negedge clk);
    sbWe   = 1'b0;
    vectors = vectors + 1;
    if (superBank !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL sb_idle_update: got superBank=%b, expected 0", superBank);
    end
  endtask

  initial begin
    test_reset();
    test_fb_and_read();
    test_bb_view();
    test_reset_mid_mem();
    test_blocked_write();
    test_mem_write();
    test_timeout();
    test_superbank();
    repeat (3) @(negedge clk);
    vectors = vectors + 1;
    if (expQ.size() != 0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL missing_acks: got %0d completions outstanding, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
